// File: rtl/ase_sim_local_mem_burst_split.sv
// Avalon-MM burst splitter: reissues upstream bursts as downstream bursts of at most
// MAX_BURST beats through a one-deep command register, plus a one-deep read-data register.
module ase_sim_local_mem_burst_split #(
   parameter int ADDR_WIDTH        = 27,
   parameter int DATA_WIDTH        = 512,
   parameter int BURST_CNT_WIDTH   = 7,
   parameter int MAX_BURST         = 4,
   parameter int M_BURST_CNT_WIDTH = $clog2(MAX_BURST) + 1
) (
   input  logic                         clk,
   input  logic                         reset_n,
   output logic                         s_waitrequest,
   input  logic                         s_read,
   input  logic                         s_write,
   input  logic [ADDR_WIDTH-1:0]        s_address,
   input  logic [BURST_CNT_WIDTH-1:0]   s_burstcount,
   input  logic [DATA_WIDTH-1:0]        s_writedata,
   input  logic [DATA_WIDTH/8-1:0]      s_byteenable,
   output logic [DATA_WIDTH-1:0]        s_readdata,
   output logic                         s_readdatavalid,
   input  logic                         m_waitrequest,
   output logic                         m_read,
   output logic                         m_write,
   output logic [ADDR_WIDTH-1:0]        m_address,
   output logic [M_BURST_CNT_WIDTH-1:0] m_burstcount,
   output logic [DATA_WIDTH-1:0]        m_writedata,
   output logic [DATA_WIDTH/8-1:0]      m_byteenable,
   input  logic [DATA_WIDTH-1:0]        m_readdata,
   input  logic                         m_readdatavalid
);

   localparam logic [BURST_CNT_WIDTH-1:0] MAX_BC = BURST_CNT_WIDTH'(MAX_BURST);
   localparam logic [BURST_CNT_WIDTH-1:0] ONE_BC = BURST_CNT_WIDTH'(1);

   typedef enum logic [1:0] {IDLE, RD_SPLIT, WR_BURST} state_t;

   function automatic logic [BURST_CNT_WIDTH-1:0] chunk_len(input logic [BURST_CNT_WIDTH-1:0] x);
      return (x > MAX_BC) ? MAX_BC : x;
   endfunction

   state_t                         state_reg, state_next;
   logic                           m_read_reg, m_read_next;
   logic                           m_write_reg, m_write_next;
   logic [ADDR_WIDTH-1:0]          m_address_reg, m_address_next;
   logic [M_BURST_CNT_WIDTH-1:0]   m_burstcount_reg, m_burstcount_next;
   logic [DATA_WIDTH-1:0]          m_writedata_reg, m_writedata_next;
   logic [DATA_WIDTH/8-1:0]        m_byteenable_reg, m_byteenable_next;
   logic [ADDR_WIDTH-1:0]          rd_addr_reg, rd_addr_next;
   logic [BURST_CNT_WIDTH-1:0]     rd_rem_reg, rd_rem_next;
   logic [ADDR_WIDTH-1:0]          wr_addr_reg, wr_addr_next;
   logic [BURST_CNT_WIDTH-1:0]     wr_rem_reg, wr_rem_next;
   logic [BURST_CNT_WIDTH-1:0]     chunk_rem_reg, chunk_rem_next;
   logic [DATA_WIDTH-1:0]          s_readdata_reg;
   logic                           s_readdatavalid_reg;

   logic                           load_ok;
   logic                           accept;
   logic [BURST_CNT_WIDTH-1:0]     len_bc, len_rd, len_wr;

   // The command register may be overwritten when empty or being consumed this cycle.
   assign load_ok       = !(m_read_reg || m_write_reg) || !m_waitrequest;
   assign s_waitrequest = !load_ok || (state_reg == RD_SPLIT);
   assign accept        = (s_read || s_write) && !s_waitrequest;
   assign len_bc        = chunk_len(s_burstcount);
   assign len_rd        = chunk_len(rd_rem_reg);
   assign len_wr        = chunk_len(wr_rem_reg);

   always_comb begin
      state_next        = state_reg;
      m_read_next       = m_read_reg;
      m_write_next      = m_write_reg;
      m_address_next    = m_address_reg;
      m_burstcount_next = m_burstcount_reg;
      m_writedata_next  = m_writedata_reg;
      m_byteenable_next = m_byteenable_reg;
      rd_addr_next      = rd_addr_reg;
      rd_rem_next       = rd_rem_reg;
      wr_addr_next      = wr_addr_reg;
      wr_rem_next       = wr_rem_reg;
      chunk_rem_next    = chunk_rem_reg;
      if (load_ok) begin
         m_read_next  = 1'b0;
         m_write_next = 1'b0;
         case (state_reg)
            IDLE: begin
               if (accept && s_read) begin
                  m_read_next       = 1'b1;
                  m_address_next    = s_address;
                  m_burstcount_next = M_BURST_CNT_WIDTH'(len_bc);
                  if (s_burstcount > MAX_BC) begin
                     rd_addr_next = s_address + ADDR_WIDTH'(len_bc);
                     rd_rem_next  = s_burstcount - MAX_BC;
                     state_next   = RD_SPLIT;
                  end
               end else if (accept && s_write) begin
                  m_write_next      = 1'b1;
                  m_address_next    = s_address;
                  m_burstcount_next = M_BURST_CNT_WIDTH'(len_bc);
                  m_writedata_next  = s_writedata;
                  m_byteenable_next = s_byteenable;
                  chunk_rem_next    = len_bc - ONE_BC;
                  wr_rem_next       = s_burstcount - ONE_BC;
                  wr_addr_next      = s_address + ADDR_WIDTH'(1);
                  if (s_burstcount != ONE_BC) state_next = WR_BURST;
               end
            end
            RD_SPLIT: begin
               m_read_next       = 1'b1;
               m_address_next    = rd_addr_reg;
               m_burstcount_next = M_BURST_CNT_WIDTH'(len_rd);
               rd_addr_next      = rd_addr_reg + ADDR_WIDTH'(len_rd);
               rd_rem_next       = rd_rem_reg - len_rd;
               if (rd_rem_reg <= MAX_BC) state_next = IDLE;
            end
            WR_BURST: begin
               if (accept && s_write) begin
                  m_write_next      = 1'b1;
                  m_writedata_next  = s_writedata;
                  m_byteenable_next = s_byteenable;
                  m_address_next    = wr_addr_reg;
                  wr_rem_next       = wr_rem_reg - ONE_BC;
                  wr_addr_next      = wr_addr_reg + ADDR_WIDTH'(1);
                  // A finished chunk rolls straight into the next one without a gap.
                  if (chunk_rem_reg == '0) begin
                     m_burstcount_next = M_BURST_CNT_WIDTH'(len_wr);
                     chunk_rem_next    = len_wr - ONE_BC;
                  end else begin
                     chunk_rem_next = chunk_rem_reg - ONE_BC;
                  end
                  if (wr_rem_reg == ONE_BC) state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg           <= IDLE;
         m_read_reg          <= 1'b0;
         m_write_reg         <= 1'b0;
         m_address_reg       <= '0;
         m_burstcount_reg    <= '0;
         m_writedata_reg     <= '0;
         m_byteenable_reg    <= '0;
         rd_addr_reg         <= '0;
         rd_rem_reg          <= '0;
         wr_addr_reg         <= '0;
         wr_rem_reg          <= '0;
         chunk_rem_reg       <= '0;
         s_readdata_reg      <= '0;
         s_readdatavalid_reg <= 1'b0;
      end else begin
         state_reg           <= state_next;
         m_read_reg          <= m_read_next;
         m_write_reg         <= m_write_next;
         m_address_reg       <= m_address_next;
         m_burstcount_reg    <= m_burstcount_next;
         m_writedata_reg     <= m_writedata_next;
         m_byteenable_reg    <= m_byteenable_next;
         rd_addr_reg         <= rd_addr_next;
         rd_rem_reg          <= rd_rem_next;
         wr_addr_reg         <= wr_addr_next;
         wr_rem_reg          <= wr_rem_next;
         chunk_rem_reg       <= chunk_rem_next;
         s_readdata_reg      <= m_readdata;
         s_readdatavalid_reg <= m_readdatavalid;
      end
   end

   assign m_read          = m_read_reg;
   assign m_write         = m_write_reg;
   assign m_address       = m_address_reg;
   assign m_burstcount    = m_burstcount_reg;
   assign m_writedata     = m_writedata_reg;
   assign m_byteenable    = m_byteenable_reg;
   assign s_readdata      = s_readdata_reg;
   assign s_readdatavalid = s_readdatavalid_reg;

   a_no_rd_wr: assert property (@(posedge clk) disable iff (!reset_n) !(s_read && s_write));
   a_no_rd_in_wr: assert property (@(posedge clk) disable iff (!reset_n) !(state_reg == WR_BURST && s_read));
   a_bc_nonzero: assert property (@(posedge clk) disable iff (!reset_n)
      (state_reg == IDLE && accept) |-> (s_burstcount != '0));

endmodule

// File: tb/tb_ase_sim_local_mem_burst_split.sv
// Scoreboard bench for the burst splitter: expected downstream beats and read responses
// are queued by the stimulus and checked by an independent negedge monitor.
module tb_ase_sim_local_mem_burst_split;
   localparam int AW = 27;
   localparam int DW = 512;
   localparam int BW = 7;
   localparam int MB = 4;
   localparam int MW = $clog2(MB) + 1;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          s_waitrequest;
   logic          s_read = 1'b0, s_write = 1'b0;
   logic [AW-1:0] s_address = '0;
   logic [BW-1:0] s_burstcount = '0;
   logic [DW-1:0] s_writedata = '0;
   logic [DW/8-1:0] s_byteenable = '0;
   logic [DW-1:0] s_readdata;
   logic          s_readdatavalid;
   logic          m_waitrequest;
   logic          m_read, m_write;
   logic [AW-1:0] m_address;
   logic [MW-1:0] m_burstcount;
   logic [DW-1:0] m_writedata;
   logic [DW/8-1:0] m_byteenable;
   logic [DW-1:0] m_readdata;
   logic          m_readdatavalid;

   always #5 clk = ~clk;

   ase_sim_local_mem_burst_split #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW), .MAX_BURST(MB)
   ) dut (
      .clk(clk), .reset_n(reset_n), .s_waitrequest(s_waitrequest),
      .s_read(s_read), .s_write(s_write), .s_address(s_address),
      .s_burstcount(s_burstcount), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
      .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
      .m_waitrequest(m_waitrequest), .m_read(m_read), .m_write(m_write),
      .m_address(m_address), .m_burstcount(m_burstcount), .m_writedata(m_writedata),
      .m_byteenable(m_byteenable), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid)
   );

   typedef struct {
      bit              wr;
      logic [AW-1:0]   addr;
      logic [MW-1:0]   bc;
      logic [DW-1:0]   data;
      logic [DW/8-1:0] be;
   } cmd_t;
   typedef struct {
      logic [DW-1:0] data;
      int            cyc;
   } rsp_t;

   cmd_t cmd_q[$];
   rsp_t rsp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   stall_mode = 0;
   bit   stall_pat[$];
   bit   rsp_en = 1'b0;
   int   rsp_burst = 0;
   logic [31:0] rsp_cnt = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   // Downstream stall generator: directed pattern first, else random or never.
   initial begin
      m_waitrequest = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (stall_pat.size() > 0) m_waitrequest = stall_pat.pop_front();
         else if (stall_mode != 0) m_waitrequest = ($urandom_range(0, 2) == 0);
         else m_waitrequest = 1'b0;
      end
   end

   // Downstream read-response generator; each beat's expected echo is queued.
   initial begin
      rsp_t r;
      m_readdatavalid = 1'b0;
      m_readdata = '0;
      forever begin
         @(posedge clk); #1;
         if (rsp_burst > 0) begin
            m_readdatavalid = 1'b1;
            rsp_burst--;
         end else begin
            m_readdatavalid = rsp_en && ($urandom_range(0, 1) == 1);
         end
         if (m_readdatavalid) begin
            m_readdata = rand_data();
            m_readdata[31:0] = rsp_cnt;
            rsp_cnt++;
            r.data = m_readdata;
            r.cyc = cyc;
            rsp_q.push_back(r);
         end
      end
   end

   // Monitor: transfers, stall stability and read responses.
   initial begin
      cmd_t e;
      rsp_t r;
      bit held = 1'b0;
      logic [95:0] prev_ctl = '0;
      logic [DW-1:0] prev_data = '0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            held = 1'b0;
         end else begin
            if (held) begin
               chk("hold_ctl", {m_read, m_write, m_address, m_burstcount, m_byteenable}, prev_ctl);
               chk("hold_data", m_writedata, prev_data);
            end
            held = 1'b0;
            if (m_read || m_write) begin
               if (m_waitrequest) begin
                  held = 1'b1;
                  prev_ctl = {m_read, m_write, m_address, m_burstcount, m_byteenable};
                  prev_data = m_writedata;
               end else if (cmd_q.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL cmd_unexpected: got rd=%0b wr=%0b addr=%0h expected none", m_read, m_write, m_address);
               end else begin
                  e = cmd_q.pop_front();
                  chk("cmd_write", m_write, e.wr);
                  chk("cmd_read", m_read, !e.wr);
                  chk("cmd_addr", m_address, e.addr);
                  chk("cmd_bc", m_burstcount, e.bc);
                  if (e.wr) begin
                     chk("cmd_wdata", m_writedata, e.data);
                     chk("cmd_be", m_byteenable, e.be);
                  end
               end
            end
            if (s_readdatavalid) begin
               if (rsp_q.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL rsp_unexpected: got %0h expected none", s_readdata);
               end else begin
                  r = rsp_q.pop_front();
                  chk("rsp_data", s_readdata, r.data);
                  chk("rsp_latency", cyc, r.cyc + 1);
               end
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Holds the current command until accepted; returns the cycles taken.
   task automatic handshake(output int n);
      bit acc;
      acc = 1'b0;
      n = 0;
      while (!acc) begin
         @(negedge clk);
         acc = !s_waitrequest;
         @(posedge clk); #1;
         n++;
         if (!acc && n > 300) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: got %0d cycles expected <= 300", n);
            acc = 1'b1;
         end
      end
   endtask

   task automatic do_read(input logic [AW-1:0] a, input int bc);
      cmd_t e;
      int n;
      $display("txn read  addr=%07h bc=%0d", a, bc);
      for (int off = 0; off < bc; off += MB) begin
         e.wr = 1'b0;
         e.addr = AW'(a + off);
         e.bc = MW'((bc - off > MB) ? MB : bc - off);
         e.data = '0;
         e.be = '0;
         cmd_q.push_back(e);
      end
      s_read = 1'b1;
      s_address = a;
      s_burstcount = BW'(bc);
      handshake(n);
      s_read = 1'b0;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input int bc, input int nbeats, input bit gaps, output int first_n);
      cmd_t e;
      int n;
      int c;
      $display("txn write addr=%07h bc=%0d beats=%0d", a, bc, nbeats);
      first_n = 0;
      for (int i = 0; i < nbeats; i++) begin
         c = (i / MB) * MB;
         e.wr = 1'b1;
         e.addr = AW'(a + i);
         e.bc = MW'((bc - c > MB) ? MB : bc - c);
         e.data = rand_data();
         e.be = {$urandom, $urandom};
         cmd_q.push_back(e);
         s_write = 1'b1;
         s_address = a;
         s_burstcount = BW'(bc);
         s_writedata = e.data;
         s_byteenable = e.be;
         handshake(n);
         if (i == 0) first_n = n;
         s_write = 1'b0;
         if (gaps && i + 1 < nbeats) idle($urandom_range(0, 1));
      end
   endtask

   initial begin
      int n;
      int w;
      bit is_wr;
      int bc;

      idle(2);
      chk("reset_ctl", {s_waitrequest, m_read, m_write, m_address, m_burstcount, m_byteenable, s_readdatavalid}, '0);
      chk("reset_data", m_writedata | s_readdata, '0);
      reset_n = 1'b1;

      do_write(27'h0000400, 1, 1, 1'b0, n);
      chk("first_accept_cycles", n, 1);

      do_read(27'h0000100, 10);
      w = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!s_waitrequest) break;
         w++;
      end
      @(posedge clk); #1;
      chk("rd_split_stall_cycles", w, 2);

      do_write(27'h0000200, 6, 6, 1'b0, n);
      do_read(27'h7FFFFFE, 8);
      do_read(27'h0000040, MB);
      do_read(27'h0000050, MB + 1);
      do_write(27'h7FFFFFD, MB + 1, MB + 1, 1'b0, n);

      stall_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      do_read(27'h0000500, 16);
      idle(8);

      rsp_burst = 12;
      idle(16);

      stall_mode = 1;
      rsp_en = 1'b1;
      do_read(27'h1234560, 127);
      for (int t = 0; t < 40; t++) begin
         is_wr = $urandom_range(0, 1) == 1;
         bc = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 127) : $urandom_range(1, 12);
         if (is_wr) do_write(AW'($urandom), bc, bc, 1'b1, n);
         else do_read(AW'($urandom), bc);
         idle($urandom_range(0, 2));
      end

      // Mid-burst reset: the partial burst is abandoned and outputs clear at once.
      stall_mode = 0;
      rsp_en = 1'b0;
      w = 0;
      while (cmd_q.size() != 0 && w < 2000) begin idle(1); w++; end
      idle(3);
      do_write(27'h0000600, 6, 2, 1'b0, n);
      reset_n = 1'b0;
      #1;
      chk("midrst_ctl", {s_waitrequest, m_read, m_write, m_address, m_burstcount, m_byteenable, s_readdatavalid}, '0);
      chk("midrst_data", m_writedata | s_readdata, '0);
      cmd_q.delete();
      @(posedge clk); #1;
      reset_n = 1'b1;
      do_write(27'h0000300, 1, 1, 1'b0, n);
      chk("post_reset_accept_cycles", n, 1);

      w = 0;
      while (cmd_q.size() != 0 && w < 2000) begin idle(1); w++; end
      idle(4);
      chk("cmd_q_drained", cmd_q.size(), 0);
      chk("rsp_q_drained", rsp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1, "timeout");
   end
endmodule
